// File: rtl/clock_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clock_ctrl_pkg
// Shared definitions for the fast/slow clock selection controller.
//   state_t                 : controller state, encoded HS=0, TO_LS=1, LS=2,
//                             TO_HS=3 (this encoding is visible on state_op)
//   DWELL_CYCLES_DEFAULT    : cycles spent in LS after the last host request
//   TIMEOUT_CYCLES_DEFAULT  : cycles allowed for a switch acknowledge
//   SYNC_STAGES_DEFAULT     : acknowledge synchroniser depth
// ---------------------------------------------------------------------------
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HS    = 2'd0,
        ST_TO_LS = 2'd1,
        ST_LS    = 2'd2,
        ST_TO_HS = 2'd3
    } state_t;

    localparam int DWELL_CYCLES_DEFAULT   = 4;
    localparam int TIMEOUT_CYCLES_DEFAULT = 64;
    localparam int SYNC_STAGES_DEFAULT    = 2;

endpackage : clock_ctrl_pkg

// File: rtl/sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// Multi-bit flop synchroniser for independent asynchronous level signals.
// Each bit is synchronised on its own; no coherency between bits is implied.
//   ck_ip    : destination clock
//   reset_ip : asynchronous active-high reset, clears every stage to 0
//   d_ip     : asynchronous input bits
//   q_op     : synchronised output bits (SYNC_STAGES edges of latency)
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int width       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             ck_ip,
    input  logic             reset_ip,
    input  logic [width-1:0] d_ip,
    output logic [width-1:0] q_op
);

    logic [width-1:0] stage [SYNC_STAGES];

    always_ff @(posedge ck_ip or posedge reset_ip) begin
        if (reset_ip) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d_ip;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q_op = stage[SYNC_STAGES-1];

endmodule : sync_ff

// File: rtl/clock_select_ctrl.sv
// ---------------------------------------------------------------------------
// clock_select_ctrl
// Chooses between the fast (HS) and slow (LS) CPU clock. Host-bus cycles and
// turbo-off force the slow clock; after DWELL_CYCLES quiet cycles the fast
// clock is requested again. The CPU is stalled while a switch is in flight,
// and a missing acknowledge falls back to the slow clock with a sticky flag.
//   hs_ck_ip       : free-running fast oscillator, the only clock
//   reset_ip       : asynchronous active-high reset (release synchronised
//                    upstream)
//   host_req_ip    : current CPU cycle targets the slow host bus
//   turbo_en_ip    : fast-clock operation permitted
//   selected_hs_ip : async ack, fast clock selected
//   selected_ls_ip : async ack, slow clock selected
//   select_hs_op   : registered request to the clock switch, 1 = fast
//   stall_op       : CPU ready-stall, high in TO_LS / TO_HS
//   state_op       : current state (HS=0, TO_LS=1, LS=2, TO_HS=3)
//   timeout_op     : sticky acknowledge-timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module clock_select_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES   = DWELL_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int SYNC_STAGES    = SYNC_STAGES_DEFAULT
) (
    input  logic       hs_ck_ip,
    input  logic       reset_ip,
    input  logic       host_req_ip,
    input  logic       turbo_en_ip,
    input  logic       selected_hs_ip,
    input  logic       selected_ls_ip,
    output logic       select_hs_op,
    output logic       stall_op,
    output logic [1:0] state_op,
    output logic       timeout_op
);

    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LOAD  = DW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    state_t        state;
    logic [DW-1:0] dwell_cnt;
    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_cnt_inc;
    logic [1:0]    ack_sync;
    logic          ack_hs;
    logic          ack_ls;
    logic          want_ls;

    sync_ff #(
        .width       (2),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .ck_ip    (hs_ck_ip),
        .reset_ip (reset_ip),
        .d_ip     ({selected_hs_ip, selected_ls_ip}),
        .q_op     (ack_sync)
    );

    assign ack_hs   = ack_sync[1];
    assign ack_ls   = ack_sync[0];
    assign want_ls  = host_req_ip || !turbo_en_ip;
    assign state_op = state;

    // Saturating increment of the acknowledge timeout counter.
    always_comb begin
        to_cnt_inc = to_cnt;
        if (to_cnt != TIMEOUT_MAX) begin
            to_cnt_inc = to_cnt + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below sees the pre-edge values of state and both counters.
    always_ff @(posedge hs_ck_ip or posedge reset_ip) begin
        if (reset_ip) begin
            state        <= ST_LS;
            select_hs_op <= 1'b0;
            stall_op     <= 1'b0;
            timeout_op   <= 1'b0;
            dwell_cnt    <= DWELL_LOAD;
            to_cnt       <= '0;
        end else begin
            case (state)
                ST_HS: begin
                    if (want_ls) begin
                        state        <= ST_TO_LS;
                        select_hs_op <= 1'b0;
                        stall_op     <= 1'b1;
                        to_cnt       <= '0;
                    end
                end

                ST_TO_LS: begin
                    if (ack_ls && !ack_hs) begin
                        state     <= ST_LS;
                        stall_op  <= 1'b0;
                        dwell_cnt <= DWELL_LOAD;
                        to_cnt    <= '0;
                    end else if (to_cnt_inc == TIMEOUT_MAX) begin
                        state      <= ST_LS;
                        stall_op   <= 1'b0;
                        timeout_op <= 1'b1;
                        dwell_cnt  <= DWELL_LOAD;
                        to_cnt     <= '0;
                    end else begin
                        to_cnt <= to_cnt_inc;
                    end
                end

                ST_LS: begin
                    if (want_ls) begin
                        dwell_cnt <= DWELL_LOAD;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else begin
                        state        <= ST_TO_HS;
                        select_hs_op <= 1'b1;
                        stall_op     <= 1'b1;
                        to_cnt       <= '0;
                    end
                end

                ST_TO_HS: begin
                    // A host request here does not abort the switch; it is
                    // served from HS on the edge after the acknowledge.
                    if (ack_hs && !ack_ls) begin
                        state    <= ST_HS;
                        stall_op <= 1'b0;
                        to_cnt   <= '0;
                    end else if (to_cnt_inc == TIMEOUT_MAX) begin
                        // Fall back to the slow clock, which is always safe.
                        state        <= ST_LS;
                        select_hs_op <= 1'b0;
                        stall_op     <= 1'b0;
                        timeout_op   <= 1'b1;
                        dwell_cnt    <= DWELL_LOAD;
                        to_cnt       <= '0;
                    end else begin
                        to_cnt <= to_cnt_inc;
                    end
                end

                default: begin
                    state        <= ST_LS;
                    select_hs_op <= 1'b0;
                    stall_op     <= 1'b0;
                    dwell_cnt    <= DWELL_LOAD;
                    to_cnt       <= '0;
                end
            endcase
        end
    end

endmodule : clock_select_ctrl

// File: tb/tb_clock_select_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_select_ctrl
// Scoreboard bench for clock_select_ctrl with default parameters
// (DWELL_CYCLES=4, TIMEOUT_CYCLES=64, SYNC_STAGES=2).
// ---------------------------------------------------------------------------
module tb_clock_select_ctrl;
    import clock_ctrl_pkg::*;

    logic       hs_ck_ip;
    logic       reset_ip;
    logic       host_req_ip;
    logic       turbo_en_ip;
    logic       selected_hs_ip;
    logic       selected_ls_ip;
    logic       select_hs_op;
    logic       stall_op;
    logic [1:0] state_op;
    logic       timeout_op;

    int checks_count = 0;
    int fail_count   = 0;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       sel;
        logic       stall;
        logic       to;
    } exp_t;

    exp_t sb_q[$];

    clock_select_ctrl dut (
        .hs_ck_ip       (hs_ck_ip),
        .reset_ip       (reset_ip),
        .host_req_ip    (host_req_ip),
        .turbo_en_ip    (turbo_en_ip),
        .selected_hs_ip (selected_hs_ip),
        .selected_ls_ip (selected_ls_ip),
        .select_hs_op   (select_hs_op),
        .stall_op       (stall_op),
        .state_op       (state_op),
        .timeout_op     (timeout_op)
    );

    initial hs_ck_ip = 1'b0;
    always #5 hs_ck_ip = ~hs_ck_ip;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic push_exp(input string tag, input logic [1:0] st,
                            input logic sel, input logic stall, input logic to);
        exp_t e;
        e.tag   = tag;
        e.st    = st;
        e.sel   = sel;
        e.stall = stall;
        e.to    = to;
        sb_q.push_back(e);
    endtask

    task automatic compare_outputs();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".state"},   {30'd0, state_op},     {30'd0, e.st});
            check({e.tag, ".sel_hs"},  {31'd0, select_hs_op}, {31'd0, e.sel});
            check({e.tag, ".stall"},   {31'd0, stall_op},     {31'd0, e.stall});
            check({e.tag, ".timeout"}, {31'd0, timeout_op},   {31'd0, e.to});
        end
    endtask

    // Expectation pushed with the stimulus, compared 1 ns after the next edge.
    task automatic step(input string tag, input logic [1:0] st,
                        input logic sel, input logic stall, input logic to);
        push_exp(tag, st, sel, stall, to);
        @(posedge hs_ck_ip);
        #1;
        compare_outputs();
    endtask

    // From a fresh dwell load in LS with no requests: 3 LS edges, then TO_HS.
    task automatic dwell_to_hs(input string tag, input logic to);
        for (int i = 0; i < 3; i++) step({tag, ".ls"}, ST_LS, 1'b0, 1'b0, to);
        step({tag, ".to_hs"}, ST_TO_HS, 1'b1, 1'b1, to);
    endtask

    // Acknowledge becomes visible to the FSM on the third edge.
    task automatic ack_to_hs(input string tag, input logic to);
        selected_hs_ip = 1'b1;
        selected_ls_ip = 1'b0;
        step({tag, ".wait1"}, ST_TO_HS, 1'b1, 1'b1, to);
        step({tag, ".wait2"}, ST_TO_HS, 1'b1, 1'b1, to);
        step({tag, ".hs"},    ST_HS,    1'b1, 1'b0, to);
    endtask

    task automatic ack_to_ls(input string tag, input logic to);
        selected_hs_ip = 1'b0;
        selected_ls_ip = 1'b1;
        step({tag, ".wait1"}, ST_TO_LS, 1'b0, 1'b1, to);
        step({tag, ".wait2"}, ST_TO_LS, 1'b0, 1'b1, to);
        step({tag, ".ls"},    ST_LS,    1'b0, 1'b0, to);
    endtask

    initial begin
        reset_ip       = 1'b1;
        host_req_ip    = 1'b0;
        turbo_en_ip    = 1'b1;
        selected_hs_ip = 1'b0;
        selected_ls_ip = 1'b1;
        #1;
        push_exp("reset", ST_LS, 1'b0, 1'b0, 1'b0);
        compare_outputs();
        repeat (2) @(posedge hs_ck_ip);
        #3;
        reset_ip = 1'b0;

        // Power-up: dwell in LS, then request HS and complete the switch.
        dwell_to_hs("boot", 1'b0);
        ack_to_hs("boot_ack", 1'b0);

        // Single host cycle from HS.
        host_req_ip = 1'b1;
        step("hreq.to_ls", ST_TO_LS, 1'b0, 1'b1, 1'b0);
        host_req_ip = 1'b0;
        ack_to_ls("hreq_ack", 1'b0);

        // Host pulses every third cycle keep the dwell counter reloaded.
        for (int p = 0; p < 4; p++) begin
            host_req_ip = 1'b1;
            step("pulse.req", ST_LS, 1'b0, 1'b0, 1'b0);
            host_req_ip = 1'b0;
            step("pulse.gap1", ST_LS, 1'b0, 1'b0, 1'b0);
            step("pulse.gap2", ST_LS, 1'b0, 1'b0, 1'b0);
        end
        // Last pulse was 3 edges ago; gap edges count down 2,1 -> one more
        // edge reaches 0, then TO_HS on the next: 4 edges after the pulse.
        step("pulse.tail", ST_LS, 1'b0, 1'b0, 1'b0);
        step("pulse.to_hs", ST_TO_HS, 1'b1, 1'b1, 1'b0);

        // Host request during TO_HS must not abort the switch.
        host_req_ip = 1'b1;
        ack_to_hs("late_req", 1'b0);
        step("late_req.to_ls", ST_TO_LS, 1'b0, 1'b1, 1'b0);
        host_req_ip = 1'b0;
        ack_to_ls("late_req_ack", 1'b0);
        dwell_to_hs("pre_to", 1'b0);

        // Withheld acknowledge: 63 edges in TO_HS, timeout on the 64th.
        for (int c = 1; c < 64; c++) step("tmo.wait", ST_TO_HS, 1'b1, 1'b1, 1'b0);
        step("tmo.fire", ST_LS, 1'b0, 1'b0, 1'b1);
        dwell_to_hs("tmo.sticky", 1'b1);
        ack_to_hs("tmo.sticky_ack", 1'b1);

        // Asynchronous reset in TO_LS, sampled between clock edges.
        host_req_ip = 1'b1;
        step("rst.to_ls", ST_TO_LS, 1'b0, 1'b1, 1'b1);
        host_req_ip    = 1'b0;
        selected_hs_ip = 1'b0;
        selected_ls_ip = 1'b1;
        #1;
        reset_ip = 1'b1;
        #1;
        push_exp("rst.async", ST_LS, 1'b0, 1'b0, 1'b0);
        compare_outputs();
        @(posedge hs_ck_ip);
        #3;
        reset_ip = 1'b0;

        // Turbo off holds LS; re-enabling starts the normal dwell.
        turbo_en_ip = 1'b0;
        for (int t = 0; t < 6; t++) step("noturbo.ls", ST_LS, 1'b0, 1'b0, 1'b0);
        turbo_en_ip = 1'b1;
        dwell_to_hs("turbo_on", 1'b0);
        ack_to_hs("turbo_on_ack", 1'b0);

        // Turbo off from HS forces the slow clock.
        turbo_en_ip = 1'b0;
        step("turbo_off.to_ls", ST_TO_LS, 1'b0, 1'b1, 1'b0);
        ack_to_ls("turbo_off_ack", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_count, fail_count);
        $finish;
    end

endmodule : tb_clock_select_ctrl
